// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nn_pkg
//  Description : Shared widths and activation limits for the MAC and
//                requantization datapath.
//  Revision    : 1.0  initial release
// ============================================================================
package nn_pkg;

  // Datapath widths shared by the mac array and requant stage
  localparam int ACC_W   = 24;
  localparam int OUT_W   = 8;
  localparam int BIAS_W  = 16;
  localparam int SHIFT_W = 5;

  // Signed activation range of the requantized output
  localparam int OUT_MAX = 127;
  localparam int OUT_MIN = -128;

  // Largest meaningful right shift for an ACC_W+1 bit sum
  localparam int SHIFT_MAX = 23;

  // Saturation counter width and its sticky ceiling
  localparam int                SAT_CNT_W   = 16;
  localparam logic [SAT_CNT_W-1:0] SAT_CNT_MAX = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/round_shift_sat.sv
`default_nettype none
// ============================================================================
//  Module      : round_shift_sat
//  Description : Combinational round-half-up arithmetic right shift, optional
//                ReLU and clamp of a biased accumulator to the output range.
//  Revision    : 1.0  initial release
// ============================================================================
module round_shift_sat #(
  parameter int ACC_W = nn_pkg::ACC_W,
  parameter int OUT_W = nn_pkg::OUT_W
) (
  input  logic signed [ACC_W:0]             sum,
  input  logic        [nn_pkg::SHIFT_W-1:0] shift,
  input  logic                              relu,
  output logic signed [OUT_W-1:0]           data,
  output logic                              sat_flag
);
  import nn_pkg::*;

  // One guard bit above the sum so the rounding addend never overflows
  localparam int W = ACC_W + 2;

  logic [SHIFT_W-1:0] shift_eff;
  logic signed [W-1:0] sum_x;
  logic signed [W-1:0] rnd;
  logic signed [W-1:0] biased;
  logic signed [W-1:0] shifted;
  logic signed [W-1:0] r;

  // Round, shift, rectify, then clamp to the signed activation range
  always_comb begin
    shift_eff = (shift > SHIFT_W'(SHIFT_MAX)) ? SHIFT_W'(SHIFT_MAX) : shift;
    sum_x     = {sum[ACC_W], sum};
    rnd       = '0;
    if (shift_eff != '0) begin
      rnd = W'(1) <<< (shift_eff - SHIFT_W'(1));
    end
    biased  = sum_x + rnd;
    shifted = biased >>> shift_eff;
    r       = shifted;
    // ReLU zeroing happens before the clamp, so it never counts as saturation
    if (relu && shifted[W-1]) begin
      r = '0;
    end
    sat_flag = 1'b0;
    data     = r[OUT_W-1:0];
    if (r > W'(OUT_MAX)) begin
      data     = OUT_W'(OUT_MAX);
      sat_flag = 1'b1;
    end else if (r < W'(OUT_MIN)) begin
      data     = OUT_W'(OUT_MIN);
      sat_flag = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/requant_stage.sv
`default_nettype none
// ============================================================================
//  Module      : requant_stage
//  Description : Two-stage valid/ready pipeline converting MAC accumulators to
//                8-bit activations: bias add, then round/shift/ReLU/clamp.
//                Counts saturation events.
//  Revision    : 1.0  initial release
// ============================================================================
module requant_stage #(
  parameter int ACC_W  = nn_pkg::ACC_W,
  parameter int OUT_W  = nn_pkg::OUT_W,
  parameter int BIAS_W = nn_pkg::BIAS_W
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [ACC_W-1:0]           in_acc,
  input  logic signed [BIAS_W-1:0]          in_bias,
  input  logic        [nn_pkg::SHIFT_W-1:0] cfg_shift,
  input  logic                              cfg_relu,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [OUT_W-1:0]           out_data,
  output logic        [15:0]                sat_count,
  input  logic                              sat_clr,
  output logic                              busy
);
  import nn_pkg::*;

  // Stage 1: biased sum
  logic                    s1_valid_q, s1_valid_d;
  logic signed [ACC_W:0]   s1_sum_q, s1_sum_d;
  // Stage 2: requantized activation
  logic                    s2_valid_q, s2_valid_d;
  logic signed [OUT_W-1:0] s2_data_q, s2_data_d;
  // Saturation event counter
  logic [15:0]             sat_count_q, sat_count_d;

  logic                    s2_free;
  logic                    s1_move;
  logic                    in_fire;
  logic                    ready_int;
  logic signed [OUT_W-1:0] rs_data;
  logic                    rs_sat;

  round_shift_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_round_shift_sat (
    .sum      (s1_sum_q),
    .shift    (cfg_shift),
    .relu     (cfg_relu),
    .data     (rs_data),
    .sat_flag (rs_sat)
  );

  // Handshake: each stage advances when its successor is empty or draining
  always_comb begin
    s2_free   = !s2_valid_q || out_ready;
    s1_move   = s1_valid_q && s2_free;
    ready_int = !s1_valid_q || s1_move;
    in_fire   = in_valid && ready_int;
  end

  // Next-state for both stages and the saturation counter
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_sum_d   = {in_acc[ACC_W-1], in_acc}
                 + {{(ACC_W + 1 - BIAS_W){in_bias[BIAS_W-1]}}, in_bias};
    end else if (s1_move) begin
      s1_valid_d = 1'b0;
    end

    if (s1_move) begin
      s2_valid_d = 1'b1;
      s2_data_d  = rs_data;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end

    // Clear wins over a same-cycle increment; count sticks at all-ones
    sat_count_d = sat_count_q;
    if (sat_clr) begin
      sat_count_d = '0;
    end else if (s1_move && rs_sat && (sat_count_q != SAT_CNT_MAX)) begin
      sat_count_d = sat_count_q + 16'd1;
    end
  end

  // Control and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      sat_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      sat_count_q <= sat_count_d;
    end
  end

  // Stage 1 payload is qualified by s1_valid_q and needs no reset
  always_ff @(posedge clk) begin
    s1_sum_q <= s1_sum_d;
  end

  assign in_ready  = ready_int;
  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign sat_count = sat_count_q;
  assign busy      = s1_valid_q | s2_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_requant_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_requant_stage
//  Description : Self-checking bench for requant_stage with a scoreboard fed
//                by an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_requant_stage;

  localparam int ACC_W  = 24;
  localparam int OUT_W  = 8;
  localparam int BIAS_W = 16;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [ACC_W-1:0]  in_acc = '0;
  logic signed [BIAS_W-1:0] in_bias = '0;
  logic [4:0]               cfg_shift = '0;
  logic                     cfg_relu = 1'b0;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic [15:0]              sat_count;
  logic                     sat_clr = 1'b0;
  logic                     busy;

  logic ready_fix  = 1'b1;
  logic rand_ready = 1'b0;
  logic rr_bit     = 1'b1;
  assign out_ready = rand_ready ? rr_bit : ready_fix;

  int     n_checks = 0;
  int     n_errors = 0;
  longint exp_q[$];
  longint exp_sat = 0;

  requant_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_acc    (in_acc),
    .in_bias   (in_bias),
    .cfg_shift (cfg_shift),
    .cfg_relu  (cfg_relu),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sat_count (sat_count),
    .sat_clr   (sat_clr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: round half up, arithmetic shift, ReLU, clamp to int8
  function automatic longint ref_rq(input longint acc, input longint bias,
                                    input int sh, input bit relu, output bit sat);
    longint s;
    longint r;
    int     k;
    k = (sh > 23) ? 23 : sh;
    s = acc + bias;
    if (k > 0) s = s + (longint'(1) << (k - 1));
    r = s >>> k;
    if (relu && r < 0) r = 0;
    sat = 1'b0;
    if (r > 127) begin
      r = 127; sat = 1'b1;
    end else if (r < -128) begin
      r = -128; sat = 1'b1;
    end
    return r;
  endfunction

  // Scoreboard: observe handshakes half a cycle before the capturing edge
  always @(negedge clk) begin
    bit     sat;
    longint e;
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("sb_unexpected_beat", longint'(exp_q.size()), 1);
        else check("sb_data", longint'(out_data), exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        e = ref_rq(longint'(in_acc), longint'(in_bias), int'(cfg_shift), cfg_relu, sat);
        exp_q.push_back(e);
        if (sat && exp_sat < 65535) exp_sat++;
      end
    end
  end

  // Random backpressure source
  initial forever begin
    @(posedge clk); #1;
    rr_bit = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input longint acc, input longint bias);
    int n;
    n = 0;
    in_acc   = ACC_W'(acc);
    in_bias  = BIAS_W'(bias);
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 1000) begin
        check("send_timeout", longint'(in_ready), 1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    ready_fix  = 1'b1;
    rand_ready = 1'b0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) check("drain_timeout", longint'(busy), 0);
    check("drain_sb_empty", longint'(exp_q.size()), 0);
  endtask

  task automatic one_beat(input string tag, input longint acc, input longint bias,
                          input int sh, input bit relu, input longint exp_data);
    cfg_shift = 5'(sh);
    cfg_relu  = relu;
    ready_fix = 1'b1;
    send(acc, bias);
    check({tag, "_lat1_valid"}, longint'(out_valid), 0);
    @(posedge clk); #1;
    check({tag, "_lat2_valid"}, longint'(out_valid), 1);
    check({tag, "_data"}, longint'(out_data), exp_data);
    drain();
  endtask

  task automatic rand_phase();
    logic signed [ACC_W-1:0]  ra;
    logic signed [BIAS_W-1:0] rb;
    int g;
    for (int b = 0; b < 6; b++) begin
      cfg_shift  = 5'($urandom_range(0, 31));
      cfg_relu   = 1'($urandom_range(0, 1));
      rand_ready = 1'b1;
      for (int k = 0; k < 50; k++) begin
        g = $urandom_range(0, 2);
        repeat (g) begin @(posedge clk); #1; end
        if ($urandom_range(0, 1) == 1) ra = ACC_W'($urandom);
        else ra = ACC_W'($urandom_range(0, 4095)) - 24'sd2048;
        rb = BIAS_W'($urandom);
        send(longint'(ra), longint'(rb));
      end
      drain();
      check("rand_sat_count", longint'(sat_count), exp_sat);
    end
  endtask

  initial begin
    longint hold0;
    bit     s;

    // Reset values, asserted asynchronously mid-cycle
    #2 reset = 1'b1;
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_sat_count", longint'(sat_count), 0);
    check("rst_busy", longint'(busy), 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", longint'(in_ready), 1);

    // Directed arithmetic points
    one_beat("sat150", 150, 0, 0, 0, 127);
    check("sat150_count", longint'(sat_count), 1);
    one_beat("sh3", 650, 0, 3, 0, 81);
    one_beat("sh6", 5000, -8, 6, 0, 78);
    check("nosat_count", longint'(sat_count), 1);
    one_beat("neg", -16256, 0, 7, 0, -127);
    one_beat("relu", -16256, 0, 7, 1, 0);
    check("relu_count", longint'(sat_count), 1);

    // Backpressure: two beats held, third stalls, then all drain in order
    cfg_shift = 5'd2;
    cfg_relu  = 1'b0;
    ready_fix = 1'b0;
    hold0 = ref_rq(400, 0, 2, 1'b0, s);
    send(400, 0);
    send(-300, 0);
    in_acc   = 24'sd1000;
    in_bias  = 16'sd0;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("full_in_ready", longint'(in_ready), 0);
      check("hold_out_valid", longint'(out_valid), 1);
      check("hold_out_data", longint'(out_data), hold0);
    end
    @(posedge clk); #1;
    ready_fix = 1'b1;
    send(1000, 0);
    send(-7, 0);
    drain();

    // Randomized traffic with random backpressure and configuration
    rand_phase();

    // Reset with two beats in flight
    cfg_shift = 5'd0;
    cfg_relu  = 1'b0;
    ready_fix = 1'b0;
    send(100, 0);
    send(-50, 0);
    #3 reset = 1'b1;
    #1;
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_busy", longint'(busy), 0);
    check("midrst_out_data", longint'(out_data), 0);
    check("midrst_sat_count", longint'(sat_count), 0);
    exp_q.delete();
    exp_sat = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    ready_fix = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", longint'(in_ready), 1);
    repeat (5) begin
      @(negedge clk);
      check("no_stale_beat", longint'(out_valid), 0);
    end

    // Drive the counter past its ceiling with saturating beats
    @(posedge clk); #1;
    in_acc   = 24'sd1000;
    in_bias  = 16'sd0;
    in_valid = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();
    check("sat_ceiling", longint'(sat_count), 65535);
    check("sat_ceiling_model", longint'(sat_count), exp_sat);

    // Clear coinciding with a saturating beat entering stage 2
    send(1000, 0);
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    exp_sat = 0;
    check("clr_priority", longint'(sat_count), 0);
    drain();
    check("clr_final", longint'(sat_count), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/requant_stage.md
REQUANT_STAGE -- requirements
Module: requant_stage

Interface
REQ-001 Parameter ACC_W, 24, accumulator input width (matches mac out).
REQ-002 Parameter OUT_W, 8, output activation width.
REQ-003 Parameter BIAS_W, 16, bias width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  in_acc/in_bias beat present.
REQ-007 in_ready  output  1  stage accepts beat this cycle.
REQ-008 in_acc  input  ACC_W signed  accumulated dot product from mac.
REQ-009 in_bias  input  BIAS_W signed  per-beat bias.
REQ-010 cfg_shift  input  5  right-shift amount, legal 0..23.
REQ-011 cfg_relu  input  1  1 = clamp negatives to 0.
REQ-012 out_valid  output  1  out_data valid.
REQ-013 out_ready  input  1  downstream consumes beat.
REQ-014 out_data  output  OUT_W signed  requantized activation.
REQ-015 sat_count  output  16  saturation events since reset/clear.
REQ-016 sat_clr  input  1  synchronous clear of sat_count.
REQ-017 busy  output  1  any pipeline stage holds a beat.

Function
REQ-018 Transfer occurs on a cycle where valid and ready are both high; no beat is dropped or duplicated; order preserved.
REQ-019 Stage 1 (S1) registers sum = in_acc + sign-extended in_bias at ACC_W+1 bits, no overflow possible.
REQ-020 Stage 2 (S2) registers: r = (sum + (shift>0 ? 2^(shift-1) : 0)) >>> shift (arithmetic, ACC_W+2 bits); if cfg_relu and r<0 then r=0; clamp r to [-128,127].
REQ-021 Latency in_valid&in_ready -> out_valid is exactly 2 cycles with out_ready held high; throughput 1 beat/cycle.
REQ-022 Each stage advances when its successor is empty or being drained the same cycle; in_ready = !S1_valid | S1_advance.
REQ-023 out_data/out_valid shall be held stable while out_valid & !out_ready.
REQ-024 Pipeline full (S1 and S2 occupied, out_ready low) -> in_ready low; capacity exactly 2 beats.
REQ-025 sat_count increments by 1 when a beat enters S2 with clamping to -128 or 127 applied (ReLU zeroing is not saturation); holds at 16'hFFFF.
REQ-026 sat_clr has priority over a simultaneous increment; result 0.
REQ-027 cfg_shift/cfg_relu are sampled at S2 entry; they shall only change while busy=0; cfg_shift >23 treated as 23.
REQ-028 busy = S1_valid | S2_valid.

Reset
REQ-029 reset asserted -> immediately: S1_valid=0, S2_valid=0, out_valid=0, out_data=0, sat_count=0, busy=0; in_ready=1 from the first clk edge after deassertion.
REQ-030 reset mid-operation discards all in-flight beats; no partial beat appears after release.
REQ-031 Data registers without valid bits need no reset.

Structure
REQ-032 Shared package nn_pkg holds ACC_W, OUT_W, BIAS_W, SHIFT_W=5, and OUT_MAX=127 / OUT_MIN=-128 constants, shared with mac.
REQ-033 One combinational sub-module, round_shift_sat (sum, shift, relu -> data, sat_flag), implements REQ-020 datapath; handshake stays in requant_stage.

Verification
REQ-034 acc=150, bias=0, shift=0, relu=0 -> out_data=127, sat_count=1, out_valid 2 cycles after accept.
REQ-035 acc=650, bias=0, shift=3 -> out_data=81; acc=5000, bias=-8, shift=6 -> out_data=78 (4992+32>>>6); no saturation.
REQ-036 acc=-16256, bias=0, shift=7: relu=0 -> -127; relu=1 -> 0, sat_count unchanged.
REQ-037 Stream 4 beats with out_ready low for 3 cycles: in_ready drops after 2 held beats, out_data held stable, all 4 emerge in order once out_ready=1.
REQ-038 Assert reset while 2 beats in flight -> out_valid=0 immediately, no stale beat after release; sat_count pushed to 16'hFFFF holds, sat_clr with a saturating beat -> 0.
